// File: rtl/iomem_bus_ctrl.sv
// Purpose: sequences picosoc iomem requests onto one of NSLOTS one-hot peripheral slots.
// Latency: mapped access: s_valid one cycle after accept, m_ready the cycle after slot ready; unmapped: m_ready one cycle after accept.
// Backpressure: waits on the selected slot's s_ready, bounded by TIMEOUT cycles; then completes with ERR_DATA and an error pulse.
module iomem_bus_ctrl #(
  parameter int          NSLOTS   = 8,
  parameter logic [7:0]  BASE_SEL = 8'h03,
  parameter int          TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m_valid,
  input  logic [3:0]             m_wstrb,
  input  logic [31:0]            m_addr,
  input  logic [31:0]            m_wdata,
  output logic                   m_ready,
  output logic [31:0]            m_rdata,
  output logic [NSLOTS-1:0]      s_valid,
  input  logic [NSLOTS-1:0]      s_ready,
  input  logic [32*NSLOTS-1:0]   s_rdata,
  output logic [31:0]            s_addr,
  output logic [3:0]             s_wstrb,
  output logic [31:0]            s_wdata,
  output logic                   err_irq,
  output logic [31:0]            err_addr
);

  localparam int          IW   = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int          CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
  localparam logic [7:0]  NS8  = 8'(NSLOTS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_d;
  logic [IW-1:0]       idx_q;
  logic [CW-1:0]       cnt;
  logic [7:0]          idx_full;
  logic                mapped;
  logic [NSLOTS-1:0]   onehot;
  logic [31:0]         sel_rdata;
  logic                sel_ready;
  logic                start, hit, tmo;

  // Address decode of the incoming request into a slot index and one-hot valid.
  always_comb begin
    idx_full = m_addr[31:24] - BASE_SEL;
    mapped   = (m_addr[31:24] >= BASE_SEL) && (idx_full < NS8);
    onehot   = '0;
    for (int k = 0; k < NSLOTS; k++) begin
      onehot[k] = (idx_full == 8'(k));
    end
  end

  // Mux the latched slot's ready and read data; other slots are ignored.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int k = 0; k < NSLOTS; k++) begin
      if (idx_q == IW'(k)) begin
        sel_rdata = s_rdata[32*k +: 32];
        sel_ready = s_ready[k];
      end
    end
  end

  // Next-state logic; a ready on the final timeout cycle takes priority.
  always_comb begin
    state_d = state;
    start   = 1'b0;
    hit     = 1'b0;
    tmo     = 1'b0;
    case (state)
      IDLE: begin
        if (m_valid && !m_ready) begin
          start   = 1'b1;
          state_d = mapped ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          hit     = 1'b1;
          state_d = RESP;
        end else if (cnt == TMAX) begin
          tmo     = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Request latching, slot handshake, response data and error reporting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_valid  <= '0;
      m_ready  <= 1'b0;
      err_irq  <= 1'b0;
      m_rdata  <= '0;
      s_addr   <= '0;
      s_wstrb  <= '0;
      s_wdata  <= '0;
      err_addr <= '0;
      cnt      <= '0;
      idx_q    <= '0;
    end else begin
      // RESP always returns to IDLE, so this is high for exactly one cycle.
      m_ready <= (state_d == RESP);
      err_irq <= (start && !mapped) || tmo;

      if (start) begin
        s_addr  <= m_addr;
        s_wstrb <= m_wstrb;
        s_wdata <= m_wdata;
        idx_q   <= idx_full[IW-1:0];
        if (mapped) begin
          s_valid <= onehot;
          cnt     <= '0;
        end else begin
          m_rdata <= ERR_DATA;
        end
      end

      if (hit) begin
        m_rdata <= sel_rdata;
        s_valid <= '0;
      end else if (tmo) begin
        m_rdata <= ERR_DATA;
        s_valid <= '0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 1'b1;
      end

      // err_irq is high exactly during an error RESP cycle.
      if (state == RESP && err_irq) begin
        err_addr <= s_addr;
      end
    end
  end

endmodule
